// File: rtl/mandala_pkg.sv
// Shared types and constants for the mandala per-frame animation controller.
package mandala_pkg;

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_PAUSED       = 2'd1,
    ST_STEP_PENDING = 2'd2
  } state_t;

  localparam logic [7:0] SEED_INIT           = 8'hAC;
  // Feedback taps at bits 7,5,4,3 give a maximal-length sequence, so 0 is never reached.
  localparam logic [7:0] LFSR_TAPS           = 8'b1011_1000;
  localparam int         DEBOUNCE_CYCLES_DEF = 250000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [2:0] div_limit(input logic [1:0] spd);
    logic [3:0] frames;
    frames = 4'd1 << spd;
    return 3'(frames - 4'd1);
  endfunction

endpackage

// File: rtl/mandala_button_debounce.sv
// Raw pushbutton to clean press pulse: 2-flop synchroniser, stability counter,
// debounced level and a one-cycle pulse on its rising edge.
module button_debounce
  import mandala_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DB_W            = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic            level_d;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mandala_frame_ctrl.sv
// Per-frame animation controller: vsync rise detect, pause/step FSM, frame
// divider and the animation registers, all in the pixel-clock domain.
//
//   state           | meaning
//   ST_RUN          | rises advance the animation through the frame divider
//   ST_PAUSED       | rises ignored, waiting for resume or a step press
//   ST_STEP_PENDING | next rise advances once, then back to ST_PAUSED
module mandala_frame_ctrl
  import mandala_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DB_W            = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       btn_pause,
  input  logic       btn_step,
  input  logic [1:0] speed,
  input  logic       freeze_seed,
  output logic       frame_tick,
  output logic [7:0] pattern_counter,
  output logic [5:0] color_counter,
  output logic       mode_select,
  output logic [7:0] seed,
  output logic       paused
);

  state_t     state;
  state_t     state_next;
  logic [2:0] div;
  logic [2:0] div_next;
  logic       advance;
  logic       vsync_q;
  logic       rise;
  logic       pause_press;
  logic       step_press;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_db_pause (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_pause),
    .press(pause_press)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_db_step (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_step),
    .press(step_press)
  );

  assign rise = vsync & ~vsync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      div   <= 3'd0;
    end else begin
      state <= state_next;
      div   <= div_next;
    end
  end

  always_comb begin
    state_next = state;
    div_next   = div;
    advance    = 1'b0;
    case (state)
      ST_RUN: begin
        // >= rather than == so lowering speed below div still fires next rise
        if (rise) begin
          if (div >= div_limit(speed)) begin
            div_next = 3'd0;
            advance  = 1'b1;
          end else begin
            div_next = div + 3'd1;
          end
        end
        if (pause_press) state_next = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (pause_press)     state_next = ST_RUN;
        else if (step_press) state_next = ST_STEP_PENDING;
      end
      ST_STEP_PENDING: begin
        if (pause_press) begin
          state_next = ST_RUN;
        end else if (rise) begin
          advance    = 1'b1;
          div_next   = 3'd0;
          state_next = ST_PAUSED;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // vsync_q resets high so a reset released mid-pulse yields no tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q         <= 1'b1;
      frame_tick      <= 1'b0;
      paused          <= 1'b0;
      pattern_counter <= 8'd0;
      color_counter   <= 6'd0;
      mode_select     <= 1'b0;
      seed            <= SEED_INIT;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= rise;
      paused     <= (state_next != ST_RUN);
      if (advance) begin
        pattern_counter <= pattern_counter + 8'd1;
        color_counter   <= color_counter + 6'd1;
        mode_select     <= pattern_counter[7];
        if (!freeze_seed) seed <= lfsr_next(seed);
      end
    end
  end

endmodule

// File: tb/tb_mandala_frame_ctrl.sv
// Self-checking bench for mandala_frame_ctrl with a frame-level reference model.
module tb_mandala_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       btn_pause;
  logic       btn_step;
  logic [1:0] speed;
  logic       freeze_seed;
  logic       frame_tick;
  logic [7:0] pattern_counter;
  logic [5:0] color_counter;
  logic       mode_select;
  logic [7:0] seed;
  logic       paused;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;

  // reference model: advances counted, frames since last advance, seed value
  int         m_adv;
  int         m_since;
  logic [7:0] m_seed;

  mandala_frame_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vsync          (vsync),
    .btn_pause      (btn_pause),
    .btn_step       (btn_step),
    .speed          (speed),
    .freeze_seed    (freeze_seed),
    .frame_tick     (frame_tick),
    .pattern_counter(pattern_counter),
    .color_counter  (color_counter),
    .mode_select    (mode_select),
    .seed           (seed),
    .paused         (paused)
  );

  always #5 clk = ~clk;

  task automatic step_cycle();
    @(posedge clk);
    #1;
    if (frame_tick === 1'b1) tick_cnt++;
  endtask

  task automatic do_frame(input int low_cycles);
    vsync = 1'b1;
    step_cycle();
    step_cycle();
    vsync = 1'b0;
    repeat (low_cycles) step_cycle();
  endtask

  task automatic model_reset();
    m_adv   = 0;
    m_since = 0;
    m_seed  = 8'hAC;
  endtask

  task automatic model_advance(input logic frz);
    m_adv++;
    if (!frz) m_seed = {m_seed[6:0], m_seed[7] ^ m_seed[5] ^ m_seed[4] ^ m_seed[3]};
  endtask

  // running mode: one advance per 2^speed frames
  task automatic model_run_frame(input logic [1:0] spd, input logic frz);
    m_since++;
    if (m_since >= (1 << spd)) begin
      m_since = 0;
      model_advance(frz);
    end
  endtask

  function automatic logic [7:0] exp_pattern();
    return 8'(m_adv % 256);
  endfunction

  function automatic logic [5:0] exp_color();
    return 6'(m_adv % 64);
  endfunction

  function automatic logic exp_mode();
    if (m_adv == 0) return 1'b0;
    return ((m_adv - 1) % 256) >= 128;
  endfunction

  task automatic apply_reset();
    rst_n       = 1'b0;
    vsync       = 1'b0;
    btn_pause   = 1'b0;
    btn_step    = 1'b0;
    speed       = 2'd0;
    freeze_seed = 1'b0;
    repeat (3) step_cycle();
    rst_n = 1'b1;
    step_cycle();
    model_reset();
    tick_cnt = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({frame_tick, pattern_counter, color_counter, mode_select, seed, paused} !== {1'b0, 8'd0, 6'd0, 1'b0, 8'hAC, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got tick=%0b pat=%0d col=%0d mode=%0b seed=%h paused=%0b, want 0 0 0 0 ac 0",
               frame_tick, pattern_counter, color_counter, mode_select, seed, paused);
    end
  endtask

  task automatic test_basic();
    logic [7:0] want_seed [3];
    want_seed[0] = 8'h59; want_seed[1] = 8'hB2; want_seed[2] = 8'h65;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      int t0;
      t0 = tick_cnt;
      do_frame(3);
      n_checks++;
      if (pattern_counter !== 8'(i + 1) || color_counter !== 6'(i + 1) || seed !== want_seed[i]) begin
        n_fail++;
        $display("FAIL basic_advance[%0d]: got pat=%0d col=%0d seed=%h, want %0d %0d %h",
                 i, pattern_counter, color_counter, seed, i + 1, i + 1, want_seed[i]);
      end
      n_checks++;
      if (tick_cnt - t0 !== 1) begin
        n_fail++;
        $display("FAIL basic_ticks[%0d]: got %0d ticks, want 1", i, tick_cnt - t0);
      end
    end
  endtask

  task automatic test_speed();
    apply_reset();
    speed = 2'd2;
    for (int i = 1; i <= 8; i++) begin
      do_frame(2);
      model_run_frame(speed, freeze_seed);
      n_checks++;
      if (pattern_counter !== exp_pattern()) begin
        n_fail++;
        $display("FAIL speed2_frame[%0d]: got pat=%0d, want %0d", i, pattern_counter, exp_pattern());
      end
    end
    n_checks++;
    if (pattern_counter !== 8'd2 || tick_cnt !== 8) begin
      n_fail++;
      $display("FAIL speed2_total: got pat=%0d ticks=%0d, want 2 8", pattern_counter, tick_cnt);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      if (i % 6 == 0) speed = 2'($urandom_range(0, 3));
      freeze_seed = 1'($urandom_range(0, 1));
      do_frame(int'($urandom_range(1, 3)));
      model_run_frame(speed, freeze_seed);
      n_checks++;
      if ({pattern_counter, color_counter, mode_select, seed} !== {exp_pattern(), exp_color(), exp_mode(), m_seed}) begin
        n_fail++;
        $display("FAIL random_frame[%0d]: got pat=%0d col=%0d mode=%0b seed=%h, want %0d %0d %0b %h",
                 i, pattern_counter, color_counter, mode_select, seed, exp_pattern(), exp_color(), exp_mode(), m_seed);
      end
    end
    n_checks++;
    if (tick_cnt !== 60) begin
      n_fail++;
      $display("FAIL random_ticks: got %0d, want 60", tick_cnt);
    end
  endtask

  task automatic test_pause_step();
    int first;
    logic [7:0] pat_before;
    logic       stayed;
    apply_reset();
    first = -1;
    btn_pause = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step_cycle();
      if (paused === 1'b1 && first < 0) first = c;
    end
    btn_pause = 1'b0;
    n_checks++;
    if (first < 1 || first > 8) begin
      n_fail++;
      $display("FAIL pause_latency: paused first seen at cycle %0d, want 1..8", first);
    end
    repeat (12) step_cycle();
    pat_before = pattern_counter;
    tick_cnt = 0;
    for (int i = 0; i < 5; i++) do_frame(2);
    n_checks++;
    if (pattern_counter !== pat_before || paused !== 1'b1 || tick_cnt !== 5) begin
      n_fail++;
      $display("FAIL paused_frames: got pat=%0d paused=%0b ticks=%0d, want %0d 1 5",
               pattern_counter, paused, tick_cnt, pat_before);
    end
    btn_step = 1'b1;
    repeat (6) step_cycle();
    btn_step = 1'b0;
    repeat (10) step_cycle();
    stayed = 1'b1;
    do_frame(2);
    model_advance(freeze_seed);
    if (paused !== 1'b1) stayed = 1'b0;
    n_checks++;
    if (pattern_counter !== exp_pattern() || seed !== m_seed) begin
      n_fail++;
      $display("FAIL step_advance: got pat=%0d seed=%h, want %0d %h", pattern_counter, seed, exp_pattern(), m_seed);
    end
    do_frame(2);
    if (paused !== 1'b1) stayed = 1'b0;
    n_checks++;
    if (pattern_counter !== exp_pattern() || stayed !== 1'b1) begin
      n_fail++;
      $display("FAIL step_single: got pat=%0d paused_held=%0b, want %0d 1", pattern_counter, stayed, exp_pattern());
    end
  endtask

  task automatic test_glitch();
    logic seen;
    apply_reset();
    seen = 1'b0;
    for (int r = 0; r < 6; r++) begin
      btn_pause = 1'b1;
      repeat (3) begin step_cycle(); if (paused !== 1'b0) seen = 1'b1; end
      btn_pause = 1'b0;
      step_cycle();
      if (paused !== 1'b0) seen = 1'b1;
    end
    repeat (10) begin step_cycle(); if (paused !== 1'b0) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_reject: paused went high=%0b, want 0", seen);
    end
    btn_pause = 1'b1;
    repeat (6) step_cycle();
    btn_pause = 1'b0;
    repeat (10) step_cycle();
    n_checks++;
    if (paused !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_steady_press: got paused=%0b, want 1", paused);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 1; i <= 257; i++) begin
      do_frame(2);
      model_run_frame(speed, freeze_seed);
      if (i == 128 || i == 129 || i == 256 || i == 257) begin
        n_checks++;
        if ({pattern_counter, color_counter, mode_select} !== {exp_pattern(), exp_color(), exp_mode()}) begin
          n_fail++;
          $display("FAIL wrap_adv[%0d]: got pat=%0d col=%0d mode=%0b, want %0d %0d %0b",
                   i, pattern_counter, color_counter, mode_select, exp_pattern(), exp_color(), exp_mode());
        end
      end
    end
    n_checks++;
    if (mode_select !== 1'b0 || pattern_counter !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap_257: got pat=%0d mode=%0b, want 1 0", pattern_counter, mode_select);
    end
  endtask

  task automatic test_reset_vsync_high();
    apply_reset();
    repeat (3) do_frame(2);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (pattern_counter !== 8'd0 || seed !== 8'hAC) begin
      n_fail++;
      $display("FAIL async_reset_clear: got pat=%0d seed=%h, want 0 ac", pattern_counter, seed);
    end
    vsync       = 1'b1;
    freeze_seed = 1'b1;
    speed       = 2'd0;
    repeat (3) step_cycle();
    rst_n = 1'b1;
    model_reset();
    tick_cnt = 0;
    repeat (4) step_cycle();
    n_checks++;
    if (tick_cnt !== 0 || pattern_counter !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_vsync_high: got ticks=%0d pat=%0d, want 0 0", tick_cnt, pattern_counter);
    end
    vsync = 1'b0;
    step_cycle();
    step_cycle();
    for (int i = 0; i < 4; i++) begin
      do_frame(2);
      model_run_frame(speed, freeze_seed);
    end
    n_checks++;
    if (tick_cnt !== 4 || pattern_counter !== exp_pattern() || seed !== 8'hAC) begin
      n_fail++;
      $display("FAIL freeze_seed: got ticks=%0d pat=%0d seed=%h, want 4 %0d ac", tick_cnt, pattern_counter, seed, exp_pattern());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_speed();
    test_random();
    test_pause_step();
    test_glitch();
    test_wrap();
    test_reset_vsync_high();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
